// File: rtl/bcd_add.sv
// bcd_add: registered multi-digit BCD adder with a one-cycle latency.
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   A, B      packed BCD operands, digit 0 in bits [3:0]
//   Cin       carry into digit 0
//   in_valid  accept A/B/Cin as an operation this edge
//   Sum       registered BCD sum, same packing as A
//   Cout      registered decimal carry-out in bit 0, bits [3:1] always 0
//   out_valid one-cycle pulse marking a new Sum/Cout/err
//   err       set with out_valid when any operand digit is 10..15
`timescale 1ns/1ps
module bcd_add #(
  parameter int unsigned DIGITS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  input  logic                  Cin,
  input  logic                  in_valid,
  output logic [4*DIGITS-1:0]   Sum,
  output logic [3:0]            Cout,
  output logic                  out_valid,
  output logic                  err
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] sum_c;
  logic         carry_c;
  logic         bad_c;
  logic [3:0]   a_dig;
  logic [3:0]   b_dig;
  logic [4:0]   t_c;

  logic [W-1:0] sum_d,       sum_q;
  logic [3:0]   cout_d,      cout_q;
  logic         out_valid_d, out_valid_q;
  logic         err_d,       err_q;

  // Ripple decimal carry through all digits and flag any non-BCD digit.
  always_comb begin : add_c
    sum_c   = '0;
    carry_c = Cin;
    bad_c   = 1'b0;
    a_dig   = '0;
    b_dig   = '0;
    t_c     = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      a_dig = A[4*i +: 4];
      b_dig = B[4*i +: 4];
      bad_c = bad_c | (a_dig > 4'd9) | (b_dig > 4'd9);
      t_c   = 5'(a_dig) + 5'(b_dig) + 5'(carry_c);
      if (t_c > 5'd9) begin
        sum_c[4*i +: 4] = 4'(t_c - 5'd10);
        carry_c         = 1'b1;
      end else begin
        sum_c[4*i +: 4] = t_c[3:0];
        carry_c         = 1'b0;
      end
    end
  end

  // Result registers hold their value between operations; only out_valid pulses.
  always_comb begin : next_c
    sum_d       = sum_q;
    cout_d      = cout_q;
    err_d       = err_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      out_valid_d = 1'b1;
      if (bad_c) begin
        sum_d  = '0;
        cout_d = '0;
        err_d  = 1'b1;
      end else begin
        sum_d  = sum_c;
        cout_d = {3'b000, carry_c};
        err_d  = 1'b0;
      end
    end
  end

  // Output registers; reset wins over an operation presented in the same cycle.
  always_ff @(posedge clk) begin : regs
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign out_valid = out_valid_q;
  assign err       = err_q;

endmodule

// File: tb/tb_bcd_add.sv
// tb_bcd_add: self-checking bench for bcd_add with one- and two-digit instances.
// Expected results are queued with the cycle they are due and compared when
// that cycle's outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_bcd_add;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] a1, b1, sum1, cout1;
  logic       cin1, iv1, ov1, err1;
  logic [7:0] a2, b2, sum2;
  logic [3:0] cout2;
  logic       cin2, iv2, ov2, err2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       err;
  } exp_t;

  typedef struct {
    exp_t e;
    int   due;
  } sb_t;

  typedef struct {
    int         sel;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    exp_t       e;
  } vec_t;

  sb_t  q1[$];
  sb_t  q2[$];
  sb_t  s1, s2;
  vec_t tbl[$];

  bcd_add #(.DIGITS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(cin1), .in_valid(iv1),
    .Sum(sum1), .Cout(cout1), .out_valid(ov1), .err(err1)
  );

  bcd_add #(.DIGITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .A(a2), .B(b2), .Cin(cin2), .in_valid(iv2),
    .Sum(sum2), .Cout(cout2), .out_valid(ov2), .err(err2)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decimal reference model, independent of the digit-ripple structure.
  function automatic exp_t model(input int d, input logic [7:0] a, input logic [7:0] b,
                                 input logic cin);
    exp_t e;
    int   va, vb, tot, p;
    bit   bad;
    logic [3:0] na, nb;
    va = 0; vb = 0; p = 1; bad = 0;
    e  = '0;
    for (int i = 0; i < d; i++) begin
      na = a[4*i +: 4];
      nb = b[4*i +: 4];
      if (na > 9 || nb > 9) bad = 1;
      va += int'(na) * p;
      vb += int'(nb) * p;
      p  *= 10;
    end
    if (bad) begin
      e.err = 1'b1;
    end else begin
      tot    = va + vb + int'(cin);
      e.cout = (tot >= p);
      tot    = tot % p;
      for (int i = 0; i < d; i++) begin
        e.sum[4*i +: 4] = 4'(tot % 10);
        tot = tot / 10;
      end
    end
    return e;
  endfunction

  function automatic vec_t mk(input int sel, input logic [7:0] a, input logic [7:0] b,
                              input logic cin, input logic [7:0] s, input logic co,
                              input logic er);
    vec_t v;
    v.sel = sel; v.a = a; v.b = b; v.cin = cin;
    v.e.sum = s; v.e.cout = co; v.e.err = er;
    return v;
  endfunction

  function automatic logic [3:0] rnd_nib();
    if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  task automatic drive(input int sel, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input exp_t e);
    sb_t s;
    s.e   = e;
    s.due = cyc + 1;
    if (sel == 1) begin
      a1 = a[3:0]; b1 = b[3:0]; cin1 = cin; iv1 = 1'b1; iv2 = 1'b0;
      q1.push_back(s);
    end else begin
      a2 = a; b2 = b; cin2 = cin; iv2 = 1'b1; iv1 = 1'b0;
      q2.push_back(s);
    end
    @(posedge clk); #1;
    iv1 = 1'b0;
    iv2 = 1'b0;
  endtask

  task automatic idle(input int n);
    iv1 = 1'b0;
    iv2 = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Scoreboard: every queued result must appear exactly on its due cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (q1.size() != 0 && q1[0].due == cyc) begin
        s1 = q1.pop_front();
        check("d1_out_valid", 32'(ov1), 32'd1);
        check("d1_sum", 32'(sum1), 32'(s1.e.sum[3:0]));
        check("d1_cout", 32'(cout1), 32'(s1.e.cout));
        check("d1_err", 32'(err1), 32'(s1.e.err));
      end else if (ov1) begin
        check("d1_spurious_valid", 32'(ov1), 32'd0);
      end
      if (q2.size() != 0 && q2[0].due == cyc) begin
        s2 = q2.pop_front();
        check("d2_out_valid", 32'(ov2), 32'd1);
        check("d2_sum", 32'(sum2), 32'(s2.e.sum));
        check("d2_cout", 32'(cout2), 32'(s2.e.cout));
        check("d2_err", 32'(err2), 32'(s2.e.err));
      end else if (ov2) begin
        check("d2_spurious_valid", 32'(ov2), 32'd0);
      end
    end
  end

  initial begin
    tbl.push_back(mk(1, 8'h05, 8'h04, 1'b0, 8'h09, 1'b0, 1'b0));
    tbl.push_back(mk(1, 8'h07, 8'h05, 1'b0, 8'h02, 1'b1, 1'b0));
    tbl.push_back(mk(1, 8'h09, 8'h09, 1'b1, 8'h09, 1'b1, 1'b0));
    tbl.push_back(mk(1, 8'h0A, 8'h03, 1'b0, 8'h00, 1'b0, 1'b1));
    tbl.push_back(mk(1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
    tbl.push_back(mk(1, 8'h03, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1));
    tbl.push_back(mk(1, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0));
    tbl.push_back(mk(2, 8'h99, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(2, 8'h45, 8'h38, 1'b0, 8'h83, 1'b0, 1'b0));
    tbl.push_back(mk(2, 8'h99, 8'h99, 1'b1, 8'h99, 1'b1, 1'b0));
    tbl.push_back(mk(2, 8'h0A, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1));
    tbl.push_back(mk(2, 8'hA0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1));
    tbl.push_back(mk(2, 8'h50, 8'h50, 1'b0, 8'h00, 1'b1, 1'b0));
    tbl.push_back(mk(2, 8'h19, 8'h01, 1'b0, 8'h20, 1'b0, 1'b0));

    // Reset with an operation presented: it must be discarded.
    rst_n = 1'b0;
    a1 = 4'h9; b1 = 4'h9; cin1 = 1'b0; iv1 = 1'b1;
    a2 = 8'h99; b2 = 8'h99; cin2 = 1'b1; iv2 = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_d1_sum", 32'(sum1), 32'd0);
    check("rst_d1_cout", 32'(cout1), 32'd0);
    check("rst_d1_valid", 32'(ov1), 32'd0);
    check("rst_d1_err", 32'(err1), 32'd0);
    check("rst_d2_sum", 32'(sum2), 32'd0);
    check("rst_d2_valid", 32'(ov2), 32'd0);
    rst_n = 1'b1;
    idle(2);
    check("post_rst_d1_valid", 32'(ov1), 32'd0);
    check("post_rst_d2_valid", 32'(ov2), 32'd0);

    foreach (tbl[i]) drive(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].e);
    idle(2);

    // Outputs hold after an idle edge while out_valid drops.
    drive(1, 8'h07, 8'h05, 1'b0, model(1, 8'h07, 8'h05, 1'b0));
    idle(1);
    check("hold_valid", 32'(ov1), 32'd0);
    check("hold_sum", 32'(sum1), 32'd2);
    check("hold_cout", 32'(cout1), 32'd1);
    check("hold_err", 32'(err1), 32'd0);
    drive(1, 8'h0A, 8'h03, 1'b0, model(1, 8'h0A, 8'h03, 1'b0));
    idle(1);
    check("hold_err_set", 32'(err1), 32'd1);
    check("hold_err_valid", 32'(ov1), 32'd0);

    // Exhaustive single-digit sweep, back to back.
    for (int a = 0; a < 10; a++)
      for (int b = 0; b < 10; b++)
        for (int c = 0; c < 2; c++)
          drive(1, 8'(a), 8'(b), 1'(c), model(1, 8'(a), 8'(b), 1'(c)));
    idle(2);

    // Random two-digit operations with occasional gaps and bad digits.
    for (int k = 0; k < 80; k++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = {rnd_nib(), rnd_nib()};
      rb = {rnd_nib(), rnd_nib()};
      rc = 1'($urandom_range(0, 1));
      drive(2, ra, rb, rc, model(2, ra, rb, rc));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(2);

    // Mid-run reset discards a concurrent operation and clears held results.
    drive(1, 8'h08, 8'h08, 1'b0, model(1, 8'h08, 8'h08, 1'b0));
    rst_n = 1'b0;
    a1 = 4'h9; b1 = 4'h9; cin1 = 1'b0; iv1 = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_sum", 32'(sum1), 32'd0);
    check("mid_rst_cout", 32'(cout1), 32'd0);
    check("mid_rst_valid", 32'(ov1), 32'd0);
    check("mid_rst_err", 32'(err1), 32'd0);
    rst_n = 1'b1;
    idle(2);
    check("mid_rst_idle_valid", 32'(ov1), 32'd0);
    drive(1, 8'h05, 8'h04, 1'b0, model(1, 8'h05, 8'h04, 1'b0));
    idle(3);

    check("d1_queue_drained", 32'(q1.size()), 32'd0);
    check("d2_queue_drained", 32'(q2.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
